// File: rtl/mem_stage_hs_if.sv
// Handshake/bus bundle for mem_stage_hs: EX/MEM input, data-memory port, MEM/WB slot.
// slave is the stage's view; master is the surrounding pipeline/memory view.
interface mem_stage_hs_if #(
  parameter int DW = 16,
  parameter int AW = 16,
  parameter int RW = 3
);
  logic          flush_in;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] alu_res_in;
  logic [DW-1:0] store_data_in;
  logic [DW-1:0] pc2_in;
  logic [DW-1:0] imm_eff_in;
  logic          mem_rd_in;
  logic          mem_wr_in;
  logic          rf_we_in;
  logic [RW-1:0] rf_waddr_in;
  logic [1:0]    wb_sel_in;

  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;

  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] alu_res_out;
  logic [DW-1:0] mem_rdata_out;
  logic [DW-1:0] pc2_out;
  logic [DW-1:0] imm_eff_out;
  logic          rf_we_out;
  logic [RW-1:0] rf_waddr_out;
  logic [1:0]    wb_sel_out;
  logic          mem_err_out;

  modport slave (
    input  flush_in, in_valid, alu_res_in, store_data_in, pc2_in, imm_eff_in,
           mem_rd_in, mem_wr_in, rf_we_in, rf_waddr_in, wb_sel_in,
           mem_ack, mem_rdata, out_ready,
    output in_ready, mem_req, mem_we, mem_addr, mem_wdata,
           out_valid, alu_res_out, mem_rdata_out, pc2_out, imm_eff_out,
           rf_we_out, rf_waddr_out, wb_sel_out, mem_err_out
  );

  modport master (
    output flush_in, in_valid, alu_res_in, store_data_in, pc2_in, imm_eff_in,
           mem_rd_in, mem_wr_in, rf_we_in, rf_waddr_in, wb_sel_in,
           mem_ack, mem_rdata, out_ready,
    input  in_ready, mem_req, mem_we, mem_addr, mem_wdata,
           out_valid, alu_res_out, mem_rdata_out, pc2_out, imm_eff_out,
           rf_we_out, rf_waddr_out, wb_sel_out, mem_err_out
  );
endinterface

// File: rtl/mem_stage_hs.sv
// MEM pipeline stage for a variable-latency req/ack data memory with a one-entry MEM/WB slot.
// Optional access timeout enabled by defining MEM_TIMEOUT_EN.
module mem_stage_hs #(
  parameter int DW      = 16,
  parameter int AW      = 16,
  parameter int RW      = 3,
  parameter int TIMEOUT = 15
) (
  input logic            clk,
  input logic            rst,
  mem_stage_hs_if.slave  bus
);

`ifdef MEM_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  localparam int CW = ($clog2(TIMEOUT + 1) > 4) ? $clog2(TIMEOUT + 1) : 4;

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t state_q, state_d;

  logic          in_ready_w;
  logic          accept;
  logic          mem_op;
  logic          done;
  logic          expire;
  logic          kill_now;
  logic          slot_wr_direct;
  logic          slot_wr_mem;

  logic          kill_q;
  logic [CW-1:0] cnt_q;

  // Access/payload holding registers, latched at accept.
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic          we_q;
  logic          rd_q;
  logic [DW-1:0] alu_q;
  logic [DW-1:0] pc2_q;
  logic [DW-1:0] imm_q;
  logic          rfwe_q;
  logic [RW-1:0] waddr_q;
  logic [1:0]    wbsel_q;

  // MEM/WB slot.
  logic          ov_q;
  logic [DW-1:0] alu_out_q;
  logic [DW-1:0] rdata_out_q;
  logic [DW-1:0] pc2_out_q;
  logic [DW-1:0] imm_out_q;
  logic          rfwe_out_q;
  logic [RW-1:0] waddr_out_q;
  logic [1:0]    wbsel_out_q;
  logic          err_q;

  assign in_ready_w = (state_q == IDLE) && (!ov_q || bus.out_ready);
  assign accept     = bus.in_valid && in_ready_w && !bus.flush_in;
  assign mem_op     = bus.mem_rd_in || bus.mem_wr_in;

  // An ack in the expiry cycle takes priority, so expiry implies no ack.
  assign expire   = TIMEOUT_EN && (state_q == ACCESS) && !bus.mem_ack &&
                    (cnt_q == CW'(TIMEOUT - 1));
  assign done     = (state_q == ACCESS) && (bus.mem_ack || expire);
  assign kill_now = kill_q || bus.flush_in;

  assign slot_wr_direct = (state_q == IDLE) && accept && !mem_op;
  assign slot_wr_mem    = done && !kill_now;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept && mem_op) state_d = ACCESS;
      ACCESS:  if (done)             state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      kill_q  <= 1'b0;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      rd_q    <= 1'b0;
      alu_q   <= '0;
      pc2_q   <= '0;
      imm_q   <= '0;
      rfwe_q  <= 1'b0;
      waddr_q <= '0;
      wbsel_q <= '0;
    end else begin
      state_q <= state_d;
      kill_q  <= (state_q == ACCESS && state_d == ACCESS) ? (kill_q || bus.flush_in) : 1'b0;
      cnt_q   <= (state_q == ACCESS) ? cnt_q + CW'(1) : '0;
      if (accept) begin
        addr_q  <= bus.alu_res_in[AW-1:0];
        wdata_q <= bus.store_data_in;
        // Read and write both set is handled as a store.
        we_q    <= bus.mem_wr_in;
        rd_q    <= bus.mem_rd_in && !bus.mem_wr_in;
        alu_q   <= bus.alu_res_in;
        pc2_q   <= bus.pc2_in;
        imm_q   <= bus.imm_eff_in;
        rfwe_q  <= bus.rf_we_in;
        waddr_q <= bus.rf_waddr_in;
        wbsel_q <= bus.wb_sel_in;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ov_q        <= 1'b0;
      alu_out_q   <= '0;
      rdata_out_q <= '0;
      pc2_out_q   <= '0;
      imm_out_q   <= '0;
      rfwe_out_q  <= 1'b0;
      waddr_out_q <= '0;
      wbsel_out_q <= '0;
      err_q       <= 1'b0;
    end else begin
      if (bus.flush_in)                     ov_q <= 1'b0;
      else if (slot_wr_direct || slot_wr_mem) ov_q <= 1'b1;
      else if (bus.out_ready)               ov_q <= 1'b0;

      if (slot_wr_direct) begin
        alu_out_q   <= bus.alu_res_in;
        pc2_out_q   <= bus.pc2_in;
        imm_out_q   <= bus.imm_eff_in;
        rfwe_out_q  <= bus.rf_we_in;
        waddr_out_q <= bus.rf_waddr_in;
        wbsel_out_q <= bus.wb_sel_in;
        err_q       <= 1'b0;
      end else if (slot_wr_mem) begin
        alu_out_q   <= alu_q;
        pc2_out_q   <= pc2_q;
        imm_out_q   <= imm_q;
        rfwe_out_q  <= rfwe_q && !expire;
        waddr_out_q <= waddr_q;
        wbsel_out_q <= wbsel_q;
        err_q       <= expire;
        if (bus.mem_ack && rd_q) rdata_out_q <= bus.mem_rdata;
      end
    end
  end

  assign bus.in_ready      = in_ready_w;
  assign bus.mem_req       = (state_q == ACCESS);
  assign bus.mem_we        = we_q;
  assign bus.mem_addr      = addr_q;
  assign bus.mem_wdata     = wdata_q;
  assign bus.out_valid     = ov_q;
  assign bus.alu_res_out   = alu_out_q;
  assign bus.mem_rdata_out = rdata_out_q;
  assign bus.pc2_out       = pc2_out_q;
  assign bus.imm_eff_out   = imm_out_q;
  assign bus.rf_we_out     = rfwe_out_q;
  assign bus.rf_waddr_out  = waddr_out_q;
  assign bus.wb_sel_out    = wbsel_out_q;
  assign bus.mem_err_out   = TIMEOUT_EN && err_q;

endmodule

// File: tb/tb_mem_stage_hs.sv
// Directed bench for mem_stage_hs: inputs change 1 time unit after posedge, checks 1 unit later.
module tb_mem_stage_hs;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  mem_stage_hs_if #(.DW(16), .AW(16), .RW(3)) bus ();

  mem_stage_hs #(.DW(16), .AW(16), .RW(3), .TIMEOUT(15)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.in_valid      = 1'b0;
    bus.flush_in      = 1'b0;
    bus.mem_rd_in     = 1'b0;
    bus.mem_wr_in     = 1'b0;
    bus.rf_we_in      = 1'b0;
    bus.mem_ack       = 1'b0;
    bus.mem_rdata     = '0;
  endtask

  initial begin
    int reqs;
    bus.alu_res_in    = '0;
    bus.store_data_in = '0;
    bus.pc2_in        = '0;
    bus.imm_eff_in    = '0;
    bus.rf_waddr_in   = '0;
    bus.wb_sel_in     = '0;
    bus.out_ready     = 1'b1;
    idle_inputs();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_mem_req",   32'(bus.mem_req), 0);
    chk("rst_alu_out",   32'(bus.alu_res_out), 0);
    chk("rst_mem_addr",  32'(bus.mem_addr), 0);
    chk("rst_err",       32'(bus.mem_err_out), 0);
    chk("rst_in_ready",  32'(bus.in_ready), 1);

    // Non-memory op: one-cycle latency.
    tick();
    bus.in_valid = 1'b1; bus.alu_res_in = 'h1234; bus.pc2_in = 'h0002;
    bus.imm_eff_in = 'h0005; bus.rf_we_in = 1'b1; bus.rf_waddr_in = 3'd3; bus.wb_sel_in = 2'd1;
    #1 chk("alu_in_ready", 32'(bus.in_ready), 1);
    tick();
    idle_inputs();
    #1;
    chk("alu_valid",    32'(bus.out_valid), 1);
    chk("alu_res",      32'(bus.alu_res_out), 'h1234);
    chk("alu_pc2",      32'(bus.pc2_out), 'h0002);
    chk("alu_imm",      32'(bus.imm_eff_out), 'h0005);
    chk("alu_rfwe",     32'(bus.rf_we_out), 1);
    chk("alu_waddr",    32'(bus.rf_waddr_out), 3);
    chk("alu_wbsel",    32'(bus.wb_sel_out), 1);
    chk("alu_ready",    32'(bus.in_ready), 1);
    chk("alu_no_req",   32'(bus.mem_req), 0);
    tick();
    #1 chk("alu_drained", 32'(bus.out_valid), 0);

    // Load with ack on the third request cycle.
    bus.in_valid = 1'b1; bus.mem_rd_in = 1'b1; bus.alu_res_in = 'h0040;
    bus.rf_we_in = 1'b1; bus.rf_waddr_in = 3'd5; bus.wb_sel_in = 2'd2;
    tick();
    idle_inputs();
    #1;
    chk("ld_req1",   32'(bus.mem_req), 1);
    chk("ld_we",     32'(bus.mem_we), 0);
    chk("ld_addr",   32'(bus.mem_addr), 'h0040);
    chk("ld_rdy1",   32'(bus.in_ready), 0);
    chk("ld_ov1",    32'(bus.out_valid), 0);
    tick();
    #1;
    chk("ld_req2",   32'(bus.mem_req), 1);
    chk("ld_rdy2",   32'(bus.in_ready), 0);
    tick();
    bus.mem_ack = 1'b1; bus.mem_rdata = 'hBEEF;
    #1;
    chk("ld_req3",   32'(bus.mem_req), 1);
    chk("ld_rdy3",   32'(bus.in_ready), 0);
    tick();
    idle_inputs();
    #1;
    chk("ld_req_off", 32'(bus.mem_req), 0);
    chk("ld_valid",   32'(bus.out_valid), 1);
    chk("ld_rdata",   32'(bus.mem_rdata_out), 'hBEEF);
    chk("ld_alu",     32'(bus.alu_res_out), 'h0040);
    chk("ld_waddr",   32'(bus.rf_waddr_out), 5);
    chk("ld_wbsel",   32'(bus.wb_sel_out), 2);
    chk("ld_ready",   32'(bus.in_ready), 1);

    // Store, accepted while the load result drains; ack in the first request cycle.
    bus.in_valid = 1'b1; bus.mem_wr_in = 1'b1; bus.alu_res_in = 'h0010;
    bus.store_data_in = 'h00AA; bus.rf_we_in = 1'b0;
    tick();
    idle_inputs();
    bus.mem_ack = 1'b1; bus.mem_rdata = 'h1111;
    #1;
    chk("st_req",   32'(bus.mem_req), 1);
    chk("st_we",    32'(bus.mem_we), 1);
    chk("st_addr",  32'(bus.mem_addr), 'h0010);
    chk("st_wdata", 32'(bus.mem_wdata), 'h00AA);
    chk("st_ov_drained", 32'(bus.out_valid), 0);
    tick();
    idle_inputs();
    #1;
    chk("st_valid",  32'(bus.out_valid), 1);
    chk("st_rfwe",   32'(bus.rf_we_out), 0);
    chk("st_rdata_kept", 32'(bus.mem_rdata_out), 'hBEEF);
    chk("st_req_off", 32'(bus.mem_req), 0);
    chk("st_alu",    32'(bus.alu_res_out), 'h0010);

    // Back-pressure: slot full and WB stalled.
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.alu_res_in = 'h5555; bus.rf_we_in = 1'b1;
    #1 chk("bp_ready0", 32'(bus.in_ready), 0);
    tick();
    #1;
    chk("bp_held_valid", 32'(bus.out_valid), 1);
    chk("bp_held_alu",   32'(bus.alu_res_out), 'h0010);
    bus.out_ready = 1'b1;
    #1 chk("bp_ready1", 32'(bus.in_ready), 1);
    tick();
    idle_inputs();
    #1;
    chk("bp_valid", 32'(bus.out_valid), 1);
    chk("bp_alu",   32'(bus.alu_res_out), 'h5555);
    chk("bp_rfwe",  32'(bus.rf_we_out), 1);
    tick();
    #1 chk("bp_drained", 32'(bus.out_valid), 0);

    // Flush during ACCESS: request held until ack, slot not written.
    bus.in_valid = 1'b1; bus.mem_rd_in = 1'b1; bus.alu_res_in = 'h0080; bus.rf_we_in = 1'b1;
    tick();
    idle_inputs();
    bus.flush_in = 1'b1;
    #1 chk("fl_req1", 32'(bus.mem_req), 1);
    tick();
    bus.flush_in = 1'b0;
    #1;
    chk("fl_req2", 32'(bus.mem_req), 1);
    chk("fl_ov2",  32'(bus.out_valid), 0);
    tick();
    bus.mem_ack = 1'b1; bus.mem_rdata = 'hCAFE;
    #1 chk("fl_req3", 32'(bus.mem_req), 1);
    tick();
    idle_inputs();
    #1;
    chk("fl_req_off", 32'(bus.mem_req), 0);
    chk("fl_ov",      32'(bus.out_valid), 0);
    chk("fl_rdata",   32'(bus.mem_rdata_out), 'hBEEF);
    chk("fl_ready",   32'(bus.in_ready), 1);
    bus.in_valid = 1'b1; bus.alu_res_in = 'h7777; bus.rf_we_in = 1'b1;
    tick();
    idle_inputs();
    bus.out_ready = 1'b0;
    #1;
    chk("fl_next_valid", 32'(bus.out_valid), 1);
    chk("fl_next_alu",   32'(bus.alu_res_out), 'h7777);

    // Flush in IDLE: clears the slot and blocks the offered input.
    tick();
    #1 chk("fi_held", 32'(bus.out_valid), 1);
    bus.out_ready = 1'b1;
    bus.flush_in = 1'b1; bus.in_valid = 1'b1; bus.alu_res_in = 'h9999;
    tick();
    idle_inputs();
    #1;
    chk("fi_ov",  32'(bus.out_valid), 0);
    chk("fi_alu", 32'(bus.alu_res_out), 'h7777);
    chk("fi_req", 32'(bus.mem_req), 0);

    // Read and write both set behaves as a store.
    bus.in_valid = 1'b1; bus.mem_rd_in = 1'b1; bus.mem_wr_in = 1'b1;
    bus.alu_res_in = 'h0022; bus.store_data_in = 'h0033;
    tick();
    idle_inputs();
    bus.mem_ack = 1'b1; bus.mem_rdata = 'h4444;
    #1 chk("rw_we", 32'(bus.mem_we), 1);
    tick();
    idle_inputs();
    #1;
    chk("rw_valid", 32'(bus.out_valid), 1);
    chk("rw_rdata_kept", 32'(bus.mem_rdata_out), 'hBEEF);
    tick();

    // Load without ack: timeout build gives up after 15 cycles, default build waits.
    bus.in_valid = 1'b1; bus.mem_rd_in = 1'b1; bus.alu_res_in = 'h0100;
    bus.rf_we_in = 1'b1; bus.rf_waddr_in = 3'd6;
    tick();
    idle_inputs();
    reqs = 0;
    for (int i = 0; i < 40; i++) begin
      if (!bus.mem_req) break;
      reqs++;
      tick();
    end
`ifdef MEM_TIMEOUT_EN
    chk("to_req_cycles", 32'(reqs), 15);
    chk("to_valid",      32'(bus.out_valid), 1);
    chk("to_err",        32'(bus.mem_err_out), 1);
    chk("to_rfwe",       32'(bus.rf_we_out), 0);
    chk("to_ready",      32'(bus.in_ready), 1);
    tick();
`else
    chk("wait_req_cycles", 32'(reqs), 40);
    chk("wait_ov",         32'(bus.out_valid), 0);
    bus.mem_ack = 1'b1; bus.mem_rdata = 'h5A5A;
    tick();
    idle_inputs();
    #1;
    chk("wait_valid", 32'(bus.out_valid), 1);
    chk("wait_rdata", 32'(bus.mem_rdata_out), 'h5A5A);
    chk("wait_err",   32'(bus.mem_err_out), 0);
    chk("wait_rfwe",  32'(bus.rf_we_out), 1);
    tick();
`endif

    // Reset while a request is outstanding.
    bus.in_valid = 1'b1; bus.mem_rd_in = 1'b1; bus.alu_res_in = 'h0200;
    tick();
    idle_inputs();
    #1 chk("rs_req_on", 32'(bus.mem_req), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("rs_req_off", 32'(bus.mem_req), 0);
    chk("rs_ov",      32'(bus.out_valid), 0);
    chk("rs_addr",    32'(bus.mem_addr), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
